dh_modexp_engine: RTL and testbench
===================================

DH_MODEXP_ENGINE -- requirements
Module: dh_modexp_engine

Interface
REQ-001 SHALL have parameter WIDTH, 32, bit width of G, P, Y, OUT (legal range >= 2).
REQ-002 SHALL have parameter EXP_WIDTH, 32, bit width of private exponent X (legal range >= 1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ST  input  1  start request, rising-edge detected.
REQ-006 SHALL have port MODE  input  1  0 = public key (base G), 1 = shared secret (base Y).
REQ-007 SHALL have port G  input  WIDTH  generator.
REQ-008 SHALL have port P  input  WIDTH  prime modulus.
REQ-009 SHALL have port Y  input  WIDTH  peer public key.
REQ-010 SHALL have port X  input  EXP_WIDTH  private exponent.
REQ-011 SHALL have port OUT  output  WIDTH  result, base^X mod P.
REQ-012 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-014 SHALL have port ERR  output  1  invalid-modulus flag for the last operation.

Function
REQ-015 SHALL detect start as ST=1 at a clock edge while the registered previous ST value is 0 and FSM is in IDLE.
REQ-016 SHALL ignore start edges while BUSY=1; ST held high SHALL start exactly one operation.
REQ-017 SHALL latch MODE, P, X and the selected base (G or Y) on the start edge; input changes while BUSY=1 SHALL have no effect.
REQ-018 SHALL use FSM states IDLE, REDUCE, SQR, MUL, FIN.
- IDLE -> REDUCE on start, or -> FIN if latched P < 2.
- REDUCE -> SQR after WIDTH cycles.
- SQR -> MUL after WIDTH cycles; MUL -> SQR after WIDTH cycles while exponent bits remain, else -> FIN.
- FIN -> IDLE after 1 cycle.
REQ-019 SHALL clear ERR to 0 on every start edge, and SHALL set BUSY=1 on the start edge through FIN inclusive.
REQ-020 SHALL implement every modular multiply as an interleaved shift-add of WIDTH iterations, one multiplier bit per cycle, MSB first: acc = (2*acc mod P) + (bit ? a : 0), then mod P; intermediates are WIDTH+1 bits; no hardware multiplier or divider.
REQ-021 REDUCE SHALL compute b = base mod P as 1*base through the same datapath.
REQ-022 SHALL run left-to-right exponentiation over all EXP_WIDTH bits of X, MSB first, starting from r = 1: SQR computes r = r*r mod P; MUL computes t = r*b mod P and commits r = t only when the current X bit is 1 (dummy multiply otherwise, for constant timing).
REQ-023 SHALL have latency independent of operand values: DONE SHALL assert WIDTH*(1+2*EXP_WIDTH)+1 cycles after the start edge (2081 for 32/32).
REQ-024 In FIN, SHALL load OUT with r, pulse DONE for exactly one cycle, and deassert BUSY on the following edge.
REQ-025 SHALL hold OUT and ERR until the next DONE; OUT SHALL always be < P when ERR=0.
REQ-026 If P < 2, SHALL skip computation, drive OUT=0 and ERR=1 with the DONE pulse, 1 cycle after the start edge.
REQ-027 X = 0 SHALL yield OUT = 1 (P >= 2); base = 0 mod P with X > 0 SHALL yield OUT = 0.
REQ-028 SHALL allow a new start edge in the first cycle after returning to IDLE.

Reset
REQ-029 With RST=0 at a clock edge: OUT=0, BUSY=0, DONE=0, ERR=0, FSM=IDLE, previous-ST register=0, all datapath registers cleared.
REQ-030 Reset mid-operation SHALL abort the operation without asserting DONE; ST high at reset release SHALL count as one start edge.

Verification
REQ-031 WIDTH=32, EXP_WIDTH=32, MODE=0, G=5, P=23, X=6, ST rises -> BUSY=1; DONE after 2081 cycles; OUT=8, ERR=0.
REQ-032 MODE=1, Y=19, P=23, X=6 -> OUT=2; cross-check MODE=1, Y=8, X=15 -> OUT=2 (shared-secret agreement).
REQ-033 MODE=0, G=17, P=5, X=6 -> OUT=4; X=0 -> OUT=1; both with identical 2081-cycle latency.
REQ-034 P=1 -> DONE 1 cycle after start, ERR=1, OUT=0; next start with P=23 -> ERR returns to 0.
REQ-035 RST low at cycle 500 of an operation -> outputs 0 next edge, no DONE; ST held high across release -> exactly one operation, exactly one DONE within 5000 cycles.
REQ-036 During BUSY, toggle ST and change G/X/P -> no restart; OUT matches the originally latched operands.

Source files
------------

// File: rtl/dh_modexp_engine.sv
// Diffie-Hellman modular exponentiation engine.
// Computes base^X mod P with a bit-serial shift-add modular multiplier, so no
// hardware multiplier or divider is used. Timing does not depend on the operands:
// MUL always runs, and its result is kept only when the exponent bit is 1.
module dh_modexp_engine #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ST,
  input  logic                 MODE,
  input  logic [WIDTH-1:0]     G,
  input  logic [WIDTH-1:0]     P,
  input  logic [WIDTH-1:0]     Y,
  input  logic [EXP_WIDTH-1:0] X,
  output logic [WIDTH-1:0]     OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned ECW = $clog2(EXP_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_SQR    = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic                 r_st_prev;
  logic                 r_bad;
  logic [CW-1:0]        r_cnt;
  logic [ECW-1:0]       r_ecnt;
  logic [WIDTH-1:0]     r_p;
  logic [EXP_WIDTH-1:0] r_x;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_r;
  logic [WIDTH-1:0]     r_b;

  logic                 w_start;
  logic                 w_last;
  logic                 w_last_exp;
  logic [WIDTH:0]       w_pp;
  logic [WIDTH:0]       w_dbl;
  logic [WIDTH:0]       w_red;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH-1:0]     w_r_commit;

  assign w_start    = ST & ~r_st_prev & (r_state == S_IDLE);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_last_exp = (r_ecnt == ECW'(EXP_WIDTH - 1));

  // One shift-add iteration: acc = ((2*acc mod P) + (bit ? a : 0)) mod P
  always_comb begin
    w_pp  = {1'b0, r_p};
    w_dbl = {r_acc, 1'b0};
    w_red = (w_dbl >= w_pp) ? (w_dbl - w_pp) : w_dbl;
    w_add = r_m[WIDTH-1] ? {1'b0, r_a} : '0;
    w_sum = w_red + w_add;
    w_res = (w_sum >= w_pp) ? WIDTH'(w_sum - w_pp) : WIDTH'(w_sum);
    w_r_commit = r_x[EXP_WIDTH-1] ? w_res : r_r;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = (P < WIDTH'(2)) ? S_FIN : S_REDUCE;
      S_REDUCE: if (w_last) w_state_nxt = S_SQR;
      S_SQR:    if (w_last) w_state_nxt = S_MUL;
      S_MUL:    if (w_last) w_state_nxt = w_last_exp ? S_FIN : S_SQR;
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand latching, multiplier sequencing and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_st_prev <= 1'b0;
      r_bad     <= 1'b0;
      r_cnt     <= '0;
      r_ecnt    <= '0;
      r_p       <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_m       <= '0;
      r_r       <= '0;
      r_b       <= '0;
      OUT       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      r_st_prev <= ST;
      DONE      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_p   <= P;
            r_x   <= X;
            r_bad <= (P < WIDTH'(2));
            r_acc <= '0;
            r_a   <= WIDTH'(1);
            r_m   <= MODE ? Y : G;
            r_cnt <= '0;
            BUSY  <= 1'b1;
            ERR   <= 1'b0;
          end
        end
        S_REDUCE, S_SQR, S_MUL: begin
          if (!w_last) begin
            r_acc <= w_res;
            r_m   <= r_m << 1;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_acc <= '0;
            r_cnt <= '0;
            if (r_state == S_REDUCE) begin
              // b = base mod P; exponentiation starts from r = 1
              r_b    <= w_res;
              r_r    <= WIDTH'(1);
              r_a    <= WIDTH'(1);
              r_m    <= WIDTH'(1);
              r_ecnt <= '0;
            end else if (r_state == S_SQR) begin
              // r = r*r done; set up t = r*b
              r_r <= w_res;
              r_a <= r_b;
              r_m <= w_res;
            end else begin
              // keep t only for a 1 exponent bit; set up the next square
              r_r    <= w_r_commit;
              r_a    <= w_r_commit;
              r_m    <= w_r_commit;
              r_x    <= r_x << 1;
              r_ecnt <= r_ecnt + ECW'(1);
            end
          end
        end
        S_FIN: begin
          OUT  <= r_bad ? '0 : r_r;
          ERR  <= r_bad;
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_modexp_engine.sv
// Scoreboard bench for dh_modexp_engine: stimulus queues the expected result,
// and a negedge monitor checks each DONE pulse against it.
module tb_dh_modexp_engine;

  localparam int unsigned W  = 32;
  localparam int unsigned EW = 32;
  localparam int LAT = 2081;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ST = 1'b0;
  logic          MODE = 1'b0;
  logic [W-1:0]  G = '0;
  logic [W-1:0]  P = '0;
  logic [W-1:0]  Y = '0;
  logic [EW-1:0] X = '0;
  logic [W-1:0]  OUT;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  dh_modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .MODE(MODE),
    .G(G), .P(P), .Y(Y), .X(X),
    .OUT(OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] out;
    logic         err;
    int           lat;
    int           start;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_done = 0;
  int   chk_req = 0;
  int   chk_done = 0;
  int   chk_kind = 0;
  bit   fin = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: immediate-state checks on request, scoreboard pop on each DONE
  always @(negedge CLK) begin
    exp_t e;
    if (chk_req != chk_done) begin
      chk_done = chk_done + 1;
      n_tests = n_tests + 1;
      if (chk_kind == 0) begin
        if (OUT !== '0 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL reset_zero: got OUT=%0d BUSY=%b DONE=%b ERR=%b, want all 0",
                   OUT, BUSY, DONE, ERR);
        end
      end else begin
        if (BUSY !== 1'b1) begin
          n_fail = n_fail + 1;
          $display("FAIL busy_on_start: got BUSY=%b, want 1", BUSY);
        end
      end
    end
    if (DONE === 1'b1) begin
      n_tests = n_tests + 1;
      if (q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_done: got DONE=1 at cycle %0d, want no DONE", cyc);
      end else begin
        e = q.pop_front();
        if (OUT !== e.out || ERR !== e.err || (cyc - e.start) != e.lat) begin
          n_fail = n_fail + 1;
          $display("FAIL result: got OUT=%0d ERR=%b lat=%0d, want OUT=%0d ERR=%b lat=%0d",
                   OUT, ERR, cyc - e.start, e.out, e.err, e.lat);
        end
      end
    end
    if (fin) begin
      n_tests = n_tests + 1;
      if (q.size() != 0) begin
        n_fail = n_fail + 1;
        $display("FAIL pending_done: got %0d operations without DONE, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) break;
    end
  endtask

  task automatic push_exp(input logic [W-1:0] eo, input logic ee, input int el);
    exp_t e;
    e.out = eo; e.err = ee; e.lat = el; e.start = cyc;
    q.push_back(e);
    exp_done = exp_done + 1;
  endtask

  // One operation; b2b starts in the cycle right after the previous DONE
  task automatic run_op(input logic m, input logic [W-1:0] g, input logic [W-1:0] y,
                        input logic [W-1:0] p, input logic [EW-1:0] x,
                        input logic [W-1:0] eo, input logic ee, input int el,
                        input bit disturb, input bit b2b);
    if (!b2b) repeat (2) @(negedge CLK);
    MODE = m; G = g; Y = y; P = p; X = x; ST = 1'b1;
    @(posedge CLK); #1;
    push_exp(eo, ee, el);
    chk_kind = 1; chk_req = chk_req + 1;
    @(negedge CLK);
    ST = 1'b0;
    if (disturb) begin
      repeat (6) begin
        repeat (250) @(negedge CLK);
        ST = ~ST; MODE = ~MODE;
        G = $urandom; Y = $urandom; P = $urandom; X = $urandom;
      end
      ST = 1'b0;
    end
    wait_done(5000);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1; chk_kind = 0; chk_req = chk_req + 1;
    @(negedge CLK); RST = 1'b1;

    run_op(1'b0, 32'd5,  32'd0,  32'd23, 32'd6,  32'd8, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b1, 32'd0,  32'd19, 32'd23, 32'd6,  32'd2, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b1, 32'd0,  32'd8,  32'd23, 32'd15, 32'd2, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'd17, 32'd0,  32'd5,  32'd6,  32'd4, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'd17, 32'd0,  32'd5,  32'd0,  32'd1, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'd5,  32'd0,  32'd1,  32'd6,  32'd0, 1'b1, 1,   1'b0, 1'b0);
    run_op(1'b0, 32'd5,  32'd0,  32'd23, 32'd6,  32'd8, 1'b0, LAT, 1'b0, 1'b1);
    run_op(1'b0, 32'd5,  32'd0,  32'd0,  32'd6,  32'd0, 1'b1, 1,   1'b0, 1'b0);
    run_op(1'b0, 32'd23, 32'd0,  32'd23, 32'd5,  32'd0, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'd3,  32'd0,  32'd7,  32'hFFFF_FFFF, 32'd6, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd0, 32'd23, 32'd1, 32'd11, 1'b0, LAT, 1'b0, 1'b0);
    run_op(1'b0, 32'd5,  32'd0,  32'd23, 32'd6,  32'd8, 1'b0, LAT, 1'b1, 1'b0);
    run_op(1'b1, 32'd0,  32'd19, 32'd23, 32'd6,  32'd2, 1'b0, LAT, 1'b0, 1'b1);

    // Abort mid-operation with ST held high, then release: exactly one new run
    repeat (2) @(negedge CLK);
    MODE = 1'b0; G = 32'd5; P = 32'd23; X = 32'd6; ST = 1'b1;
    repeat (500) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk_kind = 0; chk_req = chk_req + 1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    push_exp(32'd8, 1'b0, LAT);
    wait_done(5000);
    repeat (200) @(negedge CLK);
    ST = 1'b0;
    repeat (20) @(negedge CLK);

    fin = 1'b1;
    repeat (5) @(negedge CLK);
    $display("FAIL summary_timeout: got no summary, want summary");
    $fatal(1);
  end

endmodule
